toy_mcore_seq: RTL and testbench

- Sequencer for the 4x4 systolic PE mesh.
- Accepts one tile command at a time and drives the mesh's per-row control: load_en, din_en with diagonal skew, and shift_en.
- Issues read strobes to the A (streaming) and B (preload) operand buffers, whose read latency is 1 cycle.
- Frames the result shift-out and pulses done.

---
 rtl/toy_mcore_seq_if.sv | 36 +++
 rtl/toy_mcore_seq.sv | 84 ++++++++
 tb/tb_toy_mcore_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/toy_mcore_seq_if.sv
// rtl/toy_mcore_seq_if.sv - command handshake, operand buffer strobes and mesh control bundle
// slave is the sequencer side, master is the command source / mesh side.
interface toy_mcore_seq_if #(
   parameter int N   = 4,
   parameter int K_W = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [K_W-1:0]   cmd_k;
   logic             cmd_preload;
   logic             busy;
   logic             b_rd_en;
   logic [IW-1:0]    b_rd_idx;
   logic [N-1:0]     a_rd_en;
   logic [N*K_W-1:0] a_rd_idx;
   logic [N-1:0]     load_en;
   logic [N-1:0]     din_en;
   logic [N-1:0]     shift_en;
   logic             out_valid;
   logic [IW-1:0]    out_col_idx;
   logic             done;

   modport master (
      output cmd_valid, cmd_k, cmd_preload,
      input  cmd_ready, busy, b_rd_en, b_rd_idx, a_rd_en, a_rd_idx,
             load_en, din_en, shift_en, out_valid, out_col_idx, done
   );

   modport slave (
      input  cmd_valid, cmd_k, cmd_preload,
      output cmd_ready, busy, b_rd_en, b_rd_idx, a_rd_en, a_rd_idx,
             load_en, din_en, shift_en, out_valid, out_col_idx, done
   );
endinterface

// File: rtl/toy_mcore_seq.sv
// rtl/toy_mcore_seq.sv - tile sequencer for the NxN systolic PE mesh
// One phase counter t, cleared on every state change; outputs decode state and t only.
module toy_mcore_seq #(
   parameter int N   = 4,
   parameter int K_W = 8
) (
   input logic            clk,
   input logic            rst,
   toy_mcore_seq_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = K_W + IW + 1;

   typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, DRAIN, SHIFT, DONE} state_t;

   state_t         state;
   state_t         state_nx;
   logic [TW-1:0]  t;
   logic [K_W-1:0] k_q;
   logic [N-1:0]   a_en;
   logic [N-1:0]   din_q;
   logic           accept;
   logic [TW-1:0]  stream_last;

   assign accept      = bus.cmd_valid && bus.cmd_ready;
   assign stream_last = TW'(k_q) + TW'(N - 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         t     <= '0;
         k_q   <= '0;
         din_q <= '0;
      end else begin
         state <= state_nx;
         t     <= (state_nx != state || state == IDLE) ? '0 : t + TW'(1);
         if (accept) k_q <= bus.cmd_k;
         din_q <= a_en;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_k == '0)     state_nx = DONE;
               else if (bus.cmd_preload) state_nx = PRELOAD;
               else                      state_nx = STREAM;
            end
         end
         PRELOAD: if (t == TW'(N))         state_nx = STREAM;
         STREAM:  if (t == stream_last)    state_nx = DRAIN;
         DRAIN:   if (t == TW'(2 * N - 1)) state_nx = SHIFT;
         SHIFT:   if (t == TW'(N - 1))     state_nx = DONE;
         DONE:                             state_nx = IDLE;
         default:                          state_nx = IDLE;
      endcase
   end

   // Row r streams its k vectors in the window r <= t < r+k (diagonal skew).
   always_comb begin
      a_en         = '0;
      bus.a_rd_idx = '0;
      for (int r = 0; r < N; r++) begin
         if (state == STREAM && t >= TW'(r) && t < TW'(r) + TW'(k_q)) begin
            a_en[r]                      = 1'b1;
            bus.a_rd_idx[r*K_W +: K_W]   = K_W'(t - TW'(r));
         end
      end
   end

   assign bus.cmd_ready   = (state == IDLE) && !rst;
   assign bus.busy        = (state != IDLE);
   assign bus.b_rd_en     = (state == PRELOAD) && (t < TW'(N));
   assign bus.b_rd_idx    = bus.b_rd_en ? IW'(TW'(N - 1) - t) : '0;
   assign bus.load_en     = {N{(state == PRELOAD) && (t != '0)}};
   assign bus.a_rd_en     = a_en;
   assign bus.din_en      = din_q;
   assign bus.shift_en    = {N{state == SHIFT}};
   assign bus.out_valid   = (state == SHIFT);
   assign bus.out_col_idx = bus.out_valid ? IW'(t) : '0;
   assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_toy_mcore_seq.sv
// tb/tb_toy_mcore_seq.sv - self-checking bench for toy_mcore_seq
// Expected outputs come from a per-cycle window model of the command timeline.
`timescale 1ns/1ps
module tb_toy_mcore_seq;
   localparam int N   = 4;
   localparam int K_W = 8;
   localparam int IW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   toy_mcore_seq_if #(.N(N), .K_W(K_W)) bus ();
   toy_mcore_seq #(.N(N), .K_W(K_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic             cmd_ready;
      logic             busy;
      logic             b_rd_en;
      logic [IW-1:0]    b_rd_idx;
      logic [N-1:0]     a_rd_en;
      logic [N*K_W-1:0] a_rd_idx;
      logic [N-1:0]     load_en;
      logic [N-1:0]     din_en;
      logic [N-1:0]     shift_en;
      logic             out_valid;
      logic [IW-1:0]    out_col_idx;
      logic             done;
   } out_t;

   typedef struct {
      int k;
      bit pre;
      bit hold;
      int exp_done;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   function automatic int done_cycle(int k, bit pre);
      if (k == 0) return 0;
      return (pre ? N + 1 : 0) + (k + N - 1) + 2 * N + N;
   endfunction

   function automatic out_t idle_out();
      out_t o;
      o = '0;
      o.cmd_ready = 1'b1;
      return o;
   endfunction

   // Output expected c cycles after the accepting edge.
   function automatic out_t model(int k, bit pre, int c);
      out_t o;
      int   s;
      int   h;
      int   dc;
      o  = '0;
      dc = done_cycle(k, pre);
      s  = pre ? N + 1 : 0;
      h  = s + k + N - 1 + 2 * N;
      if (c > dc) return idle_out();
      o.busy = 1'b1;
      if (c == dc) o.done = 1'b1;
      if (k > 0) begin
         if (pre && c < N) begin
            o.b_rd_en  = 1'b1;
            o.b_rd_idx = IW'(N - 1 - c);
         end
         if (pre && c >= 1 && c <= N) o.load_en = '1;
         for (int r = 0; r < N; r++) begin
            if (c >= s + r && c < s + r + k) begin
               o.a_rd_en[r]               = 1'b1;
               o.a_rd_idx[r*K_W +: K_W]   = K_W'(c - s - r);
            end
            if (c >= s + r + 1 && c <= s + r + k) o.din_en[r] = 1'b1;
         end
         if (c >= h && c < h + N) begin
            o.shift_en    = '1;
            o.out_valid   = 1'b1;
            o.out_col_idx = IW'(c - h);
         end
      end
      return o;
   endfunction

   function automatic out_t sample();
      out_t a;
      a.cmd_ready   = bus.cmd_ready;
      a.busy        = bus.busy;
      a.b_rd_en     = bus.b_rd_en;
      a.b_rd_idx    = bus.b_rd_idx;
      a.a_rd_en     = bus.a_rd_en;
      a.a_rd_idx    = bus.a_rd_idx;
      a.load_en     = bus.load_en;
      a.din_en      = bus.din_en;
      a.shift_en    = bus.shift_en;
      a.out_valid   = bus.out_valid;
      a.out_col_idx = bus.out_col_idx;
      a.done        = bus.done;
      return a;
   endfunction

   task automatic check(string name, int c, out_t exp);
      out_t act;
      act = sample();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
      end
   endtask

   // Enter at a point where the DUT is about to show an IDLE cycle on the next negedge.
   task automatic run_cmd(string name, int k, bit pre, bit hold, int exp_done);
      int got_done;
      int dc;
      got_done = -1;
      dc       = done_cycle(k, pre);
      @(negedge clk);
      check({name, "_ready"}, -1, idle_out());
      bus.cmd_valid   = 1'b1;
      bus.cmd_k       = K_W'(k);
      bus.cmd_preload = pre;
      for (int c = 0; c <= dc; c++) begin
         @(negedge clk);
         if (bus.done && got_done < 0) got_done = c;
         check(name, c, model(k, pre, c));
         if (hold) begin
            bus.cmd_valid   = 1'b1;
            bus.cmd_k       = K_W'($urandom);
            bus.cmd_preload = 1'($urandom_range(0, 1));
         end else begin
            bus.cmd_valid = 1'b0;
         end
      end
      n_vec++;
      if (got_done != exp_done) begin
         n_err++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, got_done, exp_done);
      end
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{4,   1'b1, 1'b0, 24};
      tbl[1] = '{4,   1'b0, 1'b0, 19};
      tbl[2] = '{1,   1'b0, 1'b0, 16};
      tbl[3] = '{0,   1'b0, 1'b0, 0};
      tbl[4] = '{4,   1'b1, 1'b1, 24};
      tbl[5] = '{2,   1'b1, 1'b1, 22};
      tbl[6] = '{3,   1'b0, 1'b0, 18};
      tbl[7] = '{255, 1'b0, 1'b0, 270};

      bus.cmd_valid   = 1'b0;
      bus.cmd_k       = '0;
      bus.cmd_preload = 1'b0;
      rst             = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_hold", -1, out_t'(0));
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_cmd($sformatf("tbl%0d", i), tbl[i].k, tbl[i].pre, tbl[i].hold, tbl[i].exp_done);

      // Reset during STREAM cycle 3 of a k=4 run.
      @(negedge clk);
      check("rst_mid_ready", -1, idle_out());
      bus.cmd_valid   = 1'b1;
      bus.cmd_k       = 8'd4;
      bus.cmd_preload = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         check("rst_mid_run", c, model(4, 1'b0, c));
         bus.cmd_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_asserted", 4, out_t'(0));
      rst = 1'b0;
      for (int c = 5; c < 30; c++) begin
         @(negedge clk);
         check("rst_mid_after", c, idle_out());
      end

      for (int i = 0; i < 12; i++) begin
         int  k;
         bit  pre;
         bit  hold;
         int  gap;
         k    = $urandom_range(0, 12);
         pre  = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         run_cmd($sformatf("rand%0d", i), k, pre, hold, done_cycle(k, pre));
         gap = hold ? 0 : $urandom_range(0, 3);
         for (int j = 0; j < gap; j++) begin
            @(negedge clk);
            check("rand_gap", j, idle_out());
            bus.cmd_valid = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
